// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Brief    : Handshaked RV32I ALU / branch / jump-target unit, optional serial shifter
// Revision : 1.0
// ============================================================================
module alu_pipe #(
  parameter int XLEN         = 32,
  parameter int SHIFT_SERIAL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [3:0]      alu_ctrl,
  input  logic [2:0]      br_funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            cond_chk,
  output logic [XLEN-1:0] pc_next,
  output logic            busy
);

  localparam int              SHW       = $clog2(XLEN);
  localparam logic [6:0]      OP_BRANCH = 7'b1100011;
  localparam logic [6:0]      OP_JAL    = 7'b1101111;
  localparam logic [6:0]      OP_JALR   = 7'b1100111;
  localparam logic [3:0]      C_ADD = 4'b0000, C_SUB = 4'b0001, C_SLL = 4'b0010,
                              C_SLT = 4'b0011, C_SLTU = 4'b0100, C_XOR = 4'b0101,
                              C_SRL = 4'b0110, C_SRA = 4'b0111, C_OR = 4'b1000,
                              C_AND = 4'b1001;
  localparam logic [XLEN-1:0] C_FOUR    = XLEN'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            r_state, w_state_next;
  logic [XLEN-1:0]   r_shreg;
  logic [SHW-1:0]    r_cnt;
  logic [3:0]        r_shop;

  logic              w_accept, w_is_shift, w_go_serial, w_eq, w_lt, w_ltu, w_taken;
  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_sub, w_pc4, w_shift_res, w_alu, w_result, w_pc_next, w_step;
  logic              w_cond;

  function automatic logic [XLEN-1:0] shift1(input logic [3:0] op, input logic [XLEN-1:0] v);
    case (op)
      C_SLL:   shift1 = {v[XLEN-2:0], 1'b0};
      C_SRL:   shift1 = {1'b0, v[XLEN-1:1]};
      default: shift1 = {v[XLEN-1], v[XLEN-1:1]};
    endcase
  endfunction

  assign w_shamt  = src_b[SHW-1:0];
  assign w_sub    = src_a - src_b;
  assign w_pc4    = pc + C_FOUR;
  assign w_eq     = (src_a == src_b);
  assign w_lt     = ($signed(src_a) < $signed(src_b));
  assign w_ltu    = (src_a < src_b);
  assign w_accept = in_valid && in_ready;
  assign w_step   = shift1(r_shop, r_shreg);

  assign w_is_shift = (opcode != OP_BRANCH) && (opcode != OP_JAL) && (opcode != OP_JALR) &&
                      ((alu_ctrl == C_SLL) || (alu_ctrl == C_SRL) || (alu_ctrl == C_SRA));

  // Serial mode only needs the 0/1-bit case combinationally; longer shifts walk the FSM.
  generate
    if (SHIFT_SERIAL != 0) begin : g_serial
      assign w_shift_res = (w_shamt == '0) ? src_a : shift1(alu_ctrl, src_a);
      assign w_go_serial = w_is_shift && (w_shamt > SHW'(1));
    end else begin : g_barrel
      always_comb begin
        case (alu_ctrl)
          C_SLL:   w_shift_res = src_a << w_shamt;
          C_SRL:   w_shift_res = src_a >> w_shamt;
          default: w_shift_res = $unsigned($signed(src_a) >>> w_shamt);
        endcase
      end
      assign w_go_serial = 1'b0;
    end
  endgenerate

  always_comb begin
    w_alu = '0;
    case (alu_ctrl)
      C_ADD:                 w_alu = src_a + src_b;
      C_SUB:                 w_alu = w_sub;
      C_SLT:                 w_alu = {{(XLEN-1){1'b0}}, w_lt};
      C_SLTU:                w_alu = {{(XLEN-1){1'b0}}, w_ltu};
      C_XOR:                 w_alu = src_a ^ src_b;
      C_OR:                  w_alu = src_a | src_b;
      C_AND:                 w_alu = src_a & src_b;
      C_SLL, C_SRL, C_SRA:   w_alu = w_shift_res;
      default:               w_alu = '0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (br_funct3)
      3'b000:  w_taken = w_eq;
      3'b001:  w_taken = !w_eq;
      3'b100:  w_taken = w_lt;
      3'b101:  w_taken = !w_lt;
      3'b110:  w_taken = w_ltu;
      3'b111:  w_taken = !w_ltu;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_result  = w_alu;
    w_cond    = 1'b0;
    w_pc_next = w_pc4;
    case (opcode)
      OP_BRANCH: begin
        w_result  = w_sub;
        w_cond    = w_taken;
        w_pc_next = w_taken ? (pc + imm) : w_pc4;
      end
      OP_JAL: begin
        w_result  = w_pc4;
        w_cond    = 1'b1;
        w_pc_next = pc + imm;
      end
      OP_JALR: begin
        w_result  = w_pc4;
        w_cond    = 1'b1;
        w_pc_next = (src_a + imm) & ~C_FOUR >> 2 << 0 & ~XLEN'(1) | ((src_a + imm) & ~XLEN'(1));
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = w_go_serial ? S_SHIFT : S_HOLD;
      S_SHIFT: if (r_cnt == SHW'(1)) w_state_next = S_HOLD;
      S_HOLD: begin
        if (w_accept)       w_state_next = w_go_serial ? S_SHIFT : S_HOLD;
        else if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (flush) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // The accepting edge already performs the first shift step, so latency is max(1, shamt).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_shop     <= '0;
      alu_result <= '0;
      cond_chk   <= 1'b0;
      pc_next    <= '0;
    end else if (!flush) begin
      if (w_accept) begin
        cond_chk <= w_cond;
        pc_next  <= w_pc_next;
        if (w_go_serial) begin
          r_shreg <= shift1(alu_ctrl, src_a);
          r_cnt   <= w_shamt - SHW'(1);
          r_shop  <= alu_ctrl;
        end else begin
          alu_result <= w_result;
        end
      end else if (r_state == S_SHIFT) begin
        r_shreg <= w_step;
        r_cnt   <= r_cnt - SHW'(1);
        if (r_cnt == SHW'(1)) alu_result <= w_step;
      end
    end
  end

  assign in_ready  = !reset && !flush &&
                     ((r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready));
  assign out_valid = (r_state == S_HOLD);
  assign busy      = (r_state == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Brief    : Self-checking bench for alu_pipe against a behavioural model
// Revision : 1.0
// ============================================================================
module tb_alu_pipe;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, out_ready;
  logic            in_ready, out_valid, cond_chk, busy;
  logic [6:0]      opcode;
  logic [3:0]      alu_ctrl;
  logic [2:0]      br_funct3;
  logic [XLEN-1:0] src_a, src_b, pc, imm, alu_result, pc_next;

  int n_checks = 0;
  int n_fail   = 0;

  alu_pipe #(.XLEN(XLEN), .SHIFT_SERIAL(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .alu_ctrl(alu_ctrl), .br_funct3(br_funct3), .src_a(src_a),
    .src_b(src_b), .pc(pc), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .cond_chk(cond_chk), .pc_next(pc_next), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: direct arithmetic from the instruction semantics.
  function automatic void model(input logic [6:0] op, input logic [3:0] ctrl, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                                input logic [31:0] im, output logic [31:0] res, output logic c,
                                output logic [31:0] pn, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    lat = 1;
    c   = 1'b0;
    pn  = p + 4;
    res = 0;
    if (op == 7'b1100011) begin
      res = a - b;
      case (f3)
        3'b000: c = (a == b);
        3'b001: c = (a != b);
        3'b100: c = ($signed(a) < $signed(b));
        3'b101: c = ($signed(a) >= $signed(b));
        3'b110: c = (a < b);
        3'b111: c = (a >= b);
        default: c = 1'b0;
      endcase
      pn = c ? p + im : p + 4;
    end else if (op == 7'b1101111) begin
      c = 1'b1; pn = p + im; res = p + 4;
    end else if (op == 7'b1100111) begin
      c = 1'b1; pn = (a + im) & 32'hFFFF_FFFE; res = p + 4;
    end else begin
      case (ctrl)
        4'd0: res = a + b;
        4'd1: res = a - b;
        4'd2: res = a << sh;
        4'd3: res = ($signed(a) < $signed(b)) ? 1 : 0;
        4'd4: res = (a < b) ? 1 : 0;
        4'd5: res = a ^ b;
        4'd6: res = a >> sh;
        4'd7: res = $unsigned($signed(a) >>> sh);
        4'd8: res = a | b;
        4'd9: res = a & b;
        default: res = 0;
      endcase
      if (ctrl == 4'd2 || ctrl == 4'd6 || ctrl == 4'd7) lat = (sh == 0) ? 1 : sh;
    end
  endfunction

  task automatic drive(input logic [6:0] op, input logic [3:0] ctrl, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                       input logic [31:0] im);
    opcode = op; alu_ctrl = ctrl; br_funct3 = f3; src_a = a; src_b = b; pc = p; imm = im;
  endtask

  task automatic scramble();
    drive(7'($urandom), 4'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic run_op(input string tag, input logic [6:0] op, input logic [3:0] ctrl,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] im);
    logic [31:0] e_res, e_pn;
    logic        e_c, side_ok;
    int          e_lat, lat, guard;
    model(op, ctrl, f3, a, b, p, im, e_res, e_c, e_pn, e_lat);
    @(negedge clk);
    drive(op, ctrl, f3, a, b, p, im);
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) begin chk({tag, "_ready_to"}, 0, 1); in_valid = 1'b0; return; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    lat = 1;
    side_ok = 1'b1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      if (!busy || in_ready) side_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_res"}, alu_result, e_res);
    chk({tag, "_cond"}, {31'd0, cond_chk}, {31'd0, e_c});
    chk({tag, "_pcn"}, pc_next, e_pn);
    if (e_lat > 1) chk({tag, "_busy"}, {31'd0, side_ok}, 1);
  endtask

  initial begin
    logic seen;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {31'd0, in_ready}, 0);
    chk("rst_res", alu_result, 0);
    chk("rst_pcn", pc_next, 0);
    chk("rst_cond", {31'd0, cond_chk}, 0);
    reset = 1'b0;
    #1 chk("post_rst_ready", {31'd0, in_ready}, 1);

    run_op("add", 7'b0110011, 4'd0, 3'd0, 32'h1111, 32'h1010, 32'h100, 32'h0);
    run_op("beq_t", 7'b1100011, 4'd0, 3'b000, 32'h1111, 32'h1111, 32'h100, 32'h20);
    run_op("beq_n", 7'b1100011, 4'd0, 3'b000, 32'h1111, 32'h1110, 32'h100, 32'h20);
    run_op("sra4", 7'b0110011, 4'd7, 3'd0, 32'h8000_0000, 32'd4, 32'h0, 32'h0);
    run_op("sra0", 7'b0110011, 4'd7, 3'd0, 32'h8000_0000, 32'd0, 32'h0, 32'h0);
    run_op("sll1", 7'b0010011, 4'd2, 3'd0, 32'h8000_0001, 32'd1, 32'h0, 32'h0);
    run_op("blt", 7'b1100011, 4'd0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h8);
    run_op("bltu", 7'b1100011, 4'd0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h8);
    run_op("jalr", 7'b1100111, 4'd0, 3'd0, 32'h201, 32'h0, 32'h40, 32'h0);
    run_op("jal", 7'b1101111, 4'd3, 3'd0, 32'h5, 32'h6, 32'h1000, 32'hFFFF_FFF0);

    // Backpressure: hold a result three cycles, then accept in the consuming cycle.
    @(negedge clk);
    drive(7'b0110011, 4'd0, 3'd0, 32'd5, 32'd7, 32'h10, 32'h0);
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    drive(7'b0110011, 4'd5, 3'd0, 32'hF0F0_0000, 32'h0FF0_1234, 32'h20, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 1);
      chk("bp_res", alu_result, 32'd12);
      chk("bp_pcn", pc_next, 32'h14);
      chk("bp_ready", {31'd0, in_ready}, 0);
    end
    out_ready = 1'b1;
    #1 chk("bp_ready_rel", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    @(negedge clk);
    chk("bp2_valid", {31'd0, out_valid}, 1);
    chk("bp2_res", alu_result, 32'hFF00_1234);
    chk("bp2_pcn", pc_next, 32'h24);

    // Flush a long serial shift on its fifth cycle.
    @(negedge clk);
    drive(7'b0110011, 4'd2, 3'd0, 32'd1, 32'd31, 32'h0, 32'h0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("fl_busy_pre", {31'd0, busy}, 1);
    flush = 1'b1; in_valid = 1'b1;
    #1 chk("fl_ready", {31'd0, in_ready}, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("fl_busy", {31'd0, busy}, 0);
    chk("fl_ready_after", {31'd0, in_ready}, 1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("fl_no_valid", {31'd0, seen}, 0);

    // Reset in the middle of a serial shift.
    drive(7'b0110011, 4'd6, 3'd0, 32'hDEAD_BEEF, 32'd20, 32'h300, 32'h0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1 chk("mr_ready", {31'd0, in_ready}, 0);
    @(negedge clk);
    chk("mr_valid", {31'd0, out_valid}, 0);
    chk("mr_busy", {31'd0, busy}, 0);
    chk("mr_res", alu_result, 0);
    chk("mr_pcn", pc_next, 0);
    chk("mr_cond", {31'd0, cond_chk}, 0);
    reset = 1'b0;

    for (int n = 0; n < 150; n++) begin
      logic [6:0]  op;
      logic [31:0] a, b;
      case ($urandom_range(0, 5))
        0:       op = 7'b0110011;
        1:       op = 7'b0010011;
        2:       op = 7'b1100011;
        3:       op = 7'b1101111;
        4:       op = 7'b1100111;
        default: op = 7'($urandom);
      endcase
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_op("rnd", op, 4'($urandom), 3'($urandom), a, b, $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
